nf_branch_unit_bp: RTL and testbench

Parametrised branch resolution and prediction unit for the nanoFOX pipeline. It resolves all six RV32I conditional branch comparisons on XLEN-wide operands and drives `pc_src` combinationally. A 2^IDX_W-entry bimodal table of 2-bit saturating counters provides a registered taken/not-taken prediction to fetch. Resolved branches train the table, raise a registered one-cycle mispredict pulse, and are counted in saturating statistics counters.

---
 rtl/nf_branch_unit_bp.sv | 141 ++++++++++++++
 tb/tb_nf_branch_unit_bp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/nf_branch_unit_bp.sv
// Branch resolution and bimodal prediction unit for the nanoFOX pipeline.
// Resolves RV32I conditional branches, predicts with 2-bit counters and keeps hit/miss statistics.
module nf_branch_unit_bp #(
    parameter int         XLEN     = 32,
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_req,
    input  logic [XLEN-1:0]   pred_pc,
    output logic              pred_vld,
    output logic              pred_taken,
    input  logic              res_vld,
    input  logic [XLEN-1:0]   res_pc,
    input  logic [2:0]        res_type,
    input  logic              res_pred,
    input  logic [XLEN-1:0]   d1,
    input  logic [XLEN-1:0]   d2,
    output logic              pc_src,
    output logic              mispredict,
    output logic              mis_taken,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] miss_cnt
);

    localparam int DEPTH = 32'd1 << IDX_W;

    logic [1:0]        tbl_r [DEPTH];
    logic [IDX_W-1:0]  pred_idx_s;
    logic [IDX_W-1:0]  res_idx_s;
    logic              cond_s;
    logic              type_ok_s;
    logic              upd_s;
    logic              miss_s;
    logic              pred_vld_r;
    logic              pred_taken_r;
    logic              mispredict_r;
    logic              mis_taken_r;
    logic [STAT_W-1:0] br_cnt_r;
    logic [STAT_W-1:0] miss_cnt_r;
    logic              unused_s;

    // Saturating 2-bit counter step: taken counts up, not-taken counts down.
    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        if (taken) begin
            n = (c == 2'b11) ? 2'b11 : c + 2'b01;
        end else begin
            n = (c == 2'b00) ? 2'b00 : c - 2'b01;
        end
        return n;
    endfunction

    assign pred_idx_s = pred_pc[IDX_W+1:2];
    assign res_idx_s  = res_pc[IDX_W+1:2];
    assign unused_s   = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                          res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

    // Branch condition decode; funct3 010/011 are not branches.
    always_comb begin
        cond_s    = 1'b0;
        type_ok_s = 1'b1;
        case (res_type)
            3'b000:  cond_s = (d1 == d2);
            3'b001:  cond_s = (d1 != d2);
            3'b100:  cond_s = ($signed(d1) <  $signed(d2));
            3'b101:  cond_s = ($signed(d1) >= $signed(d2));
            3'b110:  cond_s = (d1 <  d2);
            3'b111:  cond_s = (d1 >= d2);
            default: begin
                cond_s    = 1'b0;
                type_ok_s = 1'b0;
            end
        endcase
    end

    assign pc_src = res_vld & type_ok_s & cond_s;
    assign upd_s  = res_vld & type_ok_s;
    // An invalid type can never be taken, so a taken prediction for it is a miss.
    assign miss_s = res_vld & (type_ok_s ? (cond_s != res_pred) : res_pred);

    // Counter table training on valid resolves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_r[i] <= CNT_INIT;
            end
        end else if (upd_s) begin
            tbl_r[res_idx_s] <= sat_step(tbl_r[res_idx_s], cond_s);
        end
    end

    // Prediction lookup; reads the pre-update counter when colliding with training.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_vld_r   <= 1'b0;
            pred_taken_r <= 1'b0;
        end else begin
            pred_vld_r <= pred_req;
            if (pred_req) begin
                pred_taken_r <= tbl_r[pred_idx_s][1];
            end
        end
    end

    // One-cycle mispredict pulse with the actual direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_r <= 1'b0;
            mis_taken_r  <= 1'b0;
        end else begin
            mispredict_r <= miss_s;
            mis_taken_r  <= miss_s & pc_src;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_r   <= {STAT_W{1'b0}};
            miss_cnt_r <= {STAT_W{1'b0}};
        end else begin
            if (upd_s && (br_cnt_r != {STAT_W{1'b1}})) begin
                br_cnt_r <= br_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
            end
            if (miss_s && (miss_cnt_r != {STAT_W{1'b1}})) begin
                miss_cnt_r <= miss_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pred_vld   = pred_vld_r;
    assign pred_taken = pred_taken_r;
    assign mispredict = mispredict_r;
    assign mis_taken  = mis_taken_r;
    assign br_cnt     = br_cnt_r;
    assign miss_cnt   = miss_cnt_r;

endmodule

// File: tb/tb_nf_branch_unit_bp.sv
// Bench for nf_branch_unit_bp: directed plan steps plus random traffic against a table/count model.
// A second instance with 4-bit statistics exercises counter saturation cheaply.
module tb_nf_branch_unit_bp;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        res_vld;
    logic [31:0] res_pc;
    logic [2:0]  res_type;
    logic        res_pred;
    logic [31:0] d1, d2;

    logic        pred_vld, pred_taken, pc_src, mispredict, mis_taken;
    logic [15:0] br_cnt, miss_cnt;
    logic        s_pred_vld, s_pred_taken, s_pc_src, s_mispredict, s_mis_taken;
    logic [3:0]  s_br_cnt, s_miss_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    int   ctr [64];
    int   brn;
    int   missn;
    logic exp_pt;

    always #5 clk = ~clk;

    nf_branch_unit_bp dut (
        .clk(clk), .rst(rst), .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_vld(pred_vld), .pred_taken(pred_taken), .res_vld(res_vld),
        .res_pc(res_pc), .res_type(res_type), .res_pred(res_pred),
        .d1(d1), .d2(d2), .pc_src(pc_src), .mispredict(mispredict),
        .mis_taken(mis_taken), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    nf_branch_unit_bp #(.STAT_W(4)) dut_s (
        .clk(clk), .rst(rst), .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_vld(s_pred_vld), .pred_taken(s_pred_taken), .res_vld(res_vld),
        .res_pc(res_pc), .res_type(res_type), .res_pred(res_pred),
        .d1(d1), .d2(d2), .pc_src(s_pc_src), .mispredict(s_mispredict),
        .mis_taken(s_mis_taken), .br_cnt(s_br_cnt), .miss_cnt(s_miss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_branch(input logic [2:0] t);
        return (t != 3'd2) && (t != 3'd3);
    endfunction

    function automatic bit cond(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (t)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) ctr[i] = 1;
        brn    = 0;
        missn  = 0;
        exp_pt = 1'b0;
    endtask

    task automatic check_regs();
        chk("pred_vld_s", {31'd0, s_pred_vld}, {31'd0, pred_vld});
        chk("br_cnt", {16'd0, br_cnt}, sat(brn, 16));
        chk("miss_cnt", {16'd0, miss_cnt}, sat(missn, 16));
        chk("br_cnt_small", {28'd0, s_br_cnt}, sat(brn, 4));
        chk("miss_cnt_small", {28'd0, s_miss_cnt}, sat(missn, 4));
    endtask

    // One clock of stimulus; checks pc_src mid-cycle and registered outputs after the edge.
    task automatic step(input logic rq, input logic [31:0] ppc, input logic rv,
                        input logic [31:0] rpc, input logic [2:0] rt, input logic rp,
                        input logic [31:0] a, input logic [31:0] b);
        bit tk, mp, mt;
        int pi, ri;
        pred_req = rq; pred_pc = ppc; res_vld = rv; res_pc = rpc;
        res_type = rt; res_pred = rp; d1 = a; d2 = b;
        pi = int'((ppc >> 2) & 32'h3f);
        ri = int'((rpc >> 2) & 32'h3f);
        tk = rv && is_branch(rt) && cond(rt, a, b);
        @(negedge clk);
        chk("pc_src", {31'd0, pc_src}, {31'd0, tk});
        if (rq) exp_pt = (ctr[pi] >= 2);
        mp = rv && (is_branch(rt) ? (tk != rp) : rp);
        mt = mp && tk;
        if (rv && is_branch(rt)) begin
            brn++;
            ctr[ri] = tk ? ((ctr[ri] == 3) ? 3 : ctr[ri] + 1) : ((ctr[ri] == 0) ? 0 : ctr[ri] - 1);
        end
        if (mp) missn++;
        @(posedge clk);
        #1;
        chk("pred_vld", {31'd0, pred_vld}, {31'd0, rq});
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, exp_pt});
        chk("mispredict", {31'd0, mispredict}, {31'd0, mp});
        chk("mis_taken", {31'd0, mis_taken}, {31'd0, mt});
        check_regs();
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        pred_req = 1'b0; pred_pc = 32'd0; res_vld = 1'b0; res_pc = 32'd0;
        res_type = 3'd0; res_pred = 1'b0; d1 = 32'd0; d2 = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pred_vld", {31'd0, pred_vld}, 32'd0);
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst_mis_taken", {31'd0, mis_taken}, 32'd0);
        check_regs();
        rst = 1'b0;

        // first lookup, then pred_taken must hold through an idle cycle
        step(1'b1, 32'h100, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0);
        idle();

        // every funct3 with d1=-1, d2=1, predicting not-taken
        for (int t = 0; t < 8; t++) begin
            step(1'b0, 32'd0, 1'b1, 32'h200, 3'(t), 1'b0, 32'hFFFF_FFFF, 32'd1);
        end
        // invalid types predicted taken are misses and leave the table alone
        step(1'b0, 32'd0, 1'b1, 32'h300, 3'd2, 1'b1, 32'd5, 32'd5);
        step(1'b0, 32'd0, 1'b1, 32'h300, 3'd3, 1'b1, 32'd5, 32'd5);
        step(1'b1, 32'h300, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0);

        // three taken resolves at 0x40: only the first is a miss
        step(1'b0, 32'd0, 1'b1, 32'h40, 3'd0, 1'b0, 32'd7, 32'd7);
        step(1'b0, 32'd0, 1'b1, 32'h40, 3'd0, 1'b1, 32'd7, 32'd7);
        step(1'b0, 32'd0, 1'b1, 32'h40, 3'd0, 1'b1, 32'd7, 32'd7);
        step(1'b1, 32'h40, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0);

        // same-cycle lookup and training at 0x80 reads the old counter
        step(1'b1, 32'h80, 1'b1, 32'h80, 3'd1, 1'b0, 32'd1, 32'd2);
        step(1'b1, 32'h80, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0);

        // 0x0 and 0x100 share index 0
        step(1'b1, 32'h100, 1'b1, 32'h0, 3'd6, 1'b0, 32'd1, 32'd2);
        step(1'b1, 32'h100, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0);

        // push the 4-bit statistics past saturation
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'd0, 1'b1, 32'h4, 3'd2, 1'b1, 32'd0, 32'd0);
        end

        // random traffic over a small PC pool so entries collide and saturate
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4)));
            step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                 1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 15)) << 2,
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), a, b);
        end

        // reset asserted while a mispredict pulse is high
        step(1'b0, 32'd0, 1'b1, 32'h300, 3'd0, 1'b0, 32'd5, 32'd5);
        pred_req = 1'b0; res_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("midrst_mis_taken", {31'd0, mis_taken}, 32'd0);
        chk("midrst_pred_taken", {31'd0, pred_taken}, 32'd0);
        model_reset();
        check_regs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // train each entry once: only an entry at 01 turns taken after one step
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 32'(i) << 2, 1'b1, 32'(i) << 2, 3'd0, 1'b0, 32'd3, 32'd3);
        end
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 32'(i) << 2, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
